// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the two-requester shared-timer scheduler.
package timer_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int WDOG_DEFAULT = 1023;
    localparam int NUM_REQ      = 2;
endpackage

// File: rtl/timer_sched_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse the clock after X first reads 1.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic rise
);
    logic x_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            x_q  <= x;
            rise <= x & ~x_q;
        end
    end
endmodule

// File: rtl/timer_sched.sv
// Round-robin arbiter sharing one external timer between two requesters,
// with a WAIT-state watchdog that raises a sticky ERR flag.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   X,
    input  logic [7:0]   DUR0,
    input  logic [7:0]   DUR1,
    input  logic         RDY,
    output logic         START,
    output logic [7:0]   LOAD,
    output logic [1:0]   Q,
    output logic         BUSY,
    output logic         ERR
);
    localparam int CW = (WDOG_CYCLES < 1) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG_CYCLES);

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   rise, pending, clr;
    logic                 last, grant, gnt_nxt, take;
    logic [7:0]           load_r;
    logic [CW-1:0]        wcnt;
    logic                 err;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rd
        rise_detect u_rd (
            .clk   (clk),
            .reset (reset),
            .x     (X[i]),
            .rise  (rise[i])
        );
    end

    // Both pending: serve the one not served last; otherwise whichever is pending.
    always_comb begin
        gnt_nxt = (pending == 2'b11) ? ~last : pending[1];
        take    = (state == IDLE) && (|pending);
        clr     = '0;
        if (take) clr = 2'b01 << gnt_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (|pending) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (RDY)                   state_nxt = DONE;
                else if (wcnt == WDOG_LIM) state_nxt = IDLE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            last    <= 1'b1;
            grant   <= 1'b0;
            load_r  <= '0;
            wcnt    <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            // A rise landing on the clearing edge re-queues the requester.
            pending <= (pending & ~clr) | rise;
            if (take) begin
                grant  <= gnt_nxt;
                last   <= gnt_nxt;
                load_r <= gnt_nxt ? DUR1 : DUR0;
            end
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (state == WAIT && !RDY && wcnt == WDOG_LIM) err <= 1'b1;
        end
    end

    assign START = (state == ISSUE);
    assign LOAD  = START ? load_r : 8'h00;
    assign Q     = (state == DONE) ? (2'b01 << grant) : 2'b00;
    assign BUSY  = (state != IDLE);
    assign ERR   = err;
endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed sequences, vector table and
// randomized runs against a transaction-level round-robin model.
module tb_timer_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] X = 2'b00;
    logic [7:0] DUR0 = 8'h00, DUR1 = 8'h00;
    logic       RDY = 1'b0;
    logic       START, BUSY, ERR;
    logic [7:0] LOAD;
    logic [1:0] Q;

    int errors = 0;
    int checks = 0;
    int qseen  = 0;

    timer_sched #(.WDOG_CYCLES(15)) dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .DUR0  (DUR0),
        .DUR1  (DUR1),
        .RDY   (RDY),
        .START (START),
        .LOAD  (LOAD),
        .Q     (Q),
        .BUSY  (BUSY),
        .ERR   (ERR)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    // Cycle invariants: no START with Q, Q one-hot, LOAD zero outside START.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if ((START && Q != 2'b00) || Q == 2'b11 || (!START && LOAD != 8'h00)) begin
                errors++;
                $display("FAIL invariant: START=%0b Q=%b LOAD=%h", START, Q, LOAD);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (Q != 2'b00) qseen++;
    endtask

    task automatic wait_start();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (START) begin
                ok = 1'b1;
                break;
            end
        end
        chk("start_seen", int'(ok), 1);
    endtask

    task automatic reset_dut();
        X = 2'b00; RDY = 1'b0; reset = 1'b0;
        step();
        chk("reset_outs", int'({START, LOAD, Q, BUSY, ERR}), 0);
        reset = 1'b1;
        step();
    endtask

    // One full run: START with expected LOAD, RDY after dly WAIT cycles, Q pulse.
    task automatic run_one(input logic [7:0] l, input logic [1:0] q, input int dly);
        wait_start();
        chk("load", int'(LOAD), int'(l));
        repeat (dly) step();
        RDY = 1'b1;
        step();
        RDY = 1'b0;
        chk("q_pulse", int'(Q), int'(q));
        step();
        chk("q_one_cycle", int'(Q), 0);
    endtask

    task automatic run_vec(input logic [1:0] x, input logic [7:0] d0, input logic [7:0] d1,
                           input int n, input logic [7:0] l0, input logic [1:0] q0,
                           input logic [7:0] l1, input logic [1:0] q1, input int dly);
        DUR0 = d0; DUR1 = d1; X = x;
        run_one(l0, q0, dly);
        if (n == 2) run_one(l1, q1, dly);
        X = 2'b00;
        repeat (3) step();
        chk("idle_after_vec", int'(BUSY), 0);
    endtask

    typedef struct {
        logic [1:0] x;
        logic [7:0] d0, d1;
        int         n;
        logic [7:0] l0;
        logic [1:0] q0;
        logic [7:0] l1;
        logic [1:0] q1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int qs, starts;
        logic last_m;

        // Single request timing: START 3 clocks after the rise, RDY 10 cycles later.
        reset_dut();
        DUR0 = 8'h20; X = 2'b01;
        step(); chk("a_start_c1", int'(START), 0);
        step(); chk("a_start_c2", int'(START), 0);
        step(); chk("a_start_c3", int'(START), 1);
        chk("a_load", int'(LOAD), 32'h20);
        chk("a_busy", int'(BUSY), 1);
        repeat (9) step();
        RDY = 1'b1; step(); RDY = 1'b0;
        chk("a_q", int'(Q), 1);
        step();
        chk("a_q_clear", int'(Q), 0);
        chk("a_busy_low", int'(BUSY), 0);
        X = 2'b00; repeat (2) step();

        // Vector table; expectations assume last-served=1 after reset.
        reset_dut();
        tbl[0] = '{2'b11, 8'd5,  8'd9,  2, 8'd5,  2'b01, 8'd9,  2'b10};
        tbl[1] = '{2'b01, 8'h20, 8'h77, 1, 8'h20, 2'b01, 8'h00, 2'b00};
        tbl[2] = '{2'b10, 8'h12, 8'h33, 1, 8'h33, 2'b10, 8'h00, 2'b00};
        tbl[3] = '{2'b11, 8'h01, 8'h02, 2, 8'h01, 2'b01, 8'h02, 2'b10};
        tbl[4] = '{2'b10, 8'h00, 8'hFF, 1, 8'hFF, 2'b10, 8'h00, 2'b00};
        tbl[5] = '{2'b11, 8'hAA, 8'hBB, 2, 8'hAA, 2'b01, 8'hBB, 2'b10};
        tbl[6] = '{2'b01, 8'h00, 8'h5A, 1, 8'h00, 2'b01, 8'h00, 2'b00};
        tbl[7] = '{2'b11, 8'h0C, 8'h0D, 2, 8'h0D, 2'b10, 8'h0C, 2'b01};
        for (int i = 0; i < 8; i++)
            run_vec(tbl[i].x, tbl[i].d0, tbl[i].d1, tbl[i].n,
                    tbl[i].l0, tbl[i].q0, tbl[i].l1, tbl[i].q1, 2 + i);

        // Re-request during WAIT: three toggles coalesce into one extra run.
        DUR0 = 8'h41; X = 2'b01;
        wait_start();
        chk("b_load1", int'(LOAD), 32'h41);
        step();
        repeat (3) begin
            X = 2'b00; step();
            X = 2'b01; step();
        end
        RDY = 1'b1; step(); RDY = 1'b0;
        chk("b_q1", int'(Q), 1);
        run_one(8'h41, 2'b01, 3);
        X = 2'b00;
        starts = 0;
        repeat (20) begin
            step();
            if (START) starts++;
        end
        chk("b_no_third_run", starts, 0);

        // RDY in IDLE and ISSUE is ignored.
        DUR1 = 8'h66; X = 2'b10; RDY = 1'b1;
        wait_start();
        chk("c_load", int'(LOAD), 32'h66);
        step();
        RDY = 1'b0;
        qs = qseen;
        repeat (5) step();
        chk("c_still_busy", int'(BUSY), 1);
        chk("c_no_q", qseen - qs, 0);
        RDY = 1'b1; step(); RDY = 1'b0;
        chk("c_q", int'(Q), 2);
        step(); X = 2'b00; repeat (2) step();

        // Watchdog timeout, then normal service with ERR sticky.
        DUR0 = 8'h11; X = 2'b01;
        wait_start();
        qs = qseen;
        repeat (16) step();
        chk("d_err_before", int'(ERR), 0);
        chk("d_busy_wait", int'(BUSY), 1);
        step();
        chk("d_err_set", int'(ERR), 1);
        chk("d_idle", int'(BUSY), 0);
        chk("d_no_q", qseen - qs, 0);
        X = 2'b00; step();
        DUR1 = 8'h22; X = 2'b10;
        run_one(8'h22, 2'b10, 4);
        chk("d_err_sticky", int'(ERR), 1);
        X = 2'b00; repeat (2) step();
        // RDY on the timeout cycle wins.
        DUR0 = 8'h33; X = 2'b01;
        wait_start();
        chk("d_load_race", int'(LOAD), 32'h33);
        repeat (16) step();
        RDY = 1'b1; step(); RDY = 1'b0;
        chk("d_rdy_priority", int'(Q), 1);
        step(); X = 2'b00; step();

        // Reset asserted mid-WAIT abandons the run.
        DUR1 = 8'h44; X = 2'b10;
        wait_start();
        step(); step();
        reset = 1'b0;
        #1;
        chk("e_async_clear", int'({START, LOAD, Q, BUSY, ERR}), 0);
        step();
        X = 2'b00; reset = 1'b1;
        step();
        qs = qseen;
        RDY = 1'b1; step(); RDY = 1'b0;
        repeat (5) step();
        chk("e_no_q", qseen - qs, 0);
        chk("e_idle", int'(BUSY), 0);

        // Randomized runs against a transaction-level round-robin model.
        last_m = 1'b1;
        for (int k = 0; k < 30; k++) begin
            logic [1:0] x;
            logic [7:0] d0, d1;
            logic       f;
            x  = 2'($urandom_range(1, 3));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            if (x == 2'b11) begin
                f = ~last_m;
                last_m = ~f;
                run_vec(x, d0, d1, 2, f ? d1 : d0, 2'b01 << f, f ? d0 : d1, 2'b01 << ~f,
                        int'($urandom_range(1, 8)));
            end else begin
                f = x[1];
                last_m = f;
                run_vec(x, d0, d1, 1, f ? d1 : d0, 2'b01 << f, 8'h00, 2'b00,
                        int'($urandom_range(1, 8)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
